// File: rtl/risc_pkg.sv
// Shared RV32I definitions: ALU operation encoding, opcode and funct7 constants,
// and the funct3-to-operation map that OP and OP-IMM have in common.
package risc_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  function automatic alu_op_t funct3_op(input logic [2:0] f3);
    alu_op_t op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// Fetch-side, register-file and execute-side signals of the decode stage.
interface id_stage_if;
  import risc_pkg::*;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_alu_a;
  logic [31:0] out_alu_b;
  alu_op_t     out_alu_op;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic        out_illegal;
  logic [31:0] out_pc;

  modport master (
    output in_valid, in_instr, in_pc, rs1_data, rs2_data, flush, out_ready,
    input  in_ready, rs1_addr, rs2_addr, out_valid, out_alu_a, out_alu_b,
           out_alu_op, out_rd, out_rd_we, out_illegal, out_pc
  );

  modport slave (
    input  in_valid, in_instr, in_pc, rs1_data, rs2_data, flush, out_ready,
    output in_ready, rs1_addr, rs2_addr, out_valid, out_alu_a, out_alu_b,
           out_alu_op, out_rd, out_rd_we, out_illegal, out_pc
  );

endinterface

// File: rtl/id_stage_alu_decoder.sv
// Combinational decode of ALU-class RV32I instructions into operands and operation.
module alu_decoder
  import risc_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output alu_op_t     alu_op,
  output logic        rd_we,
  output logic        illegal
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic [31:0] shamt;
  logic        legal;

  assign opcode  = instr[6:0];
  assign f3      = instr[14:12];
  assign f7      = instr[31:25];
  assign rs1_val = (instr[19:15] == 5'd0) ? 32'd0 : rs1_data;
  assign rs2_val = (instr[24:20] == 5'd0) ? 32'd0 : rs2_data;
  assign imm_i   = {{20{instr[31]}}, instr[31:20]};
  assign imm_u   = {instr[31:12], 12'b0};
  assign shamt   = {27'b0, instr[24:20]};

  // Operands are only driven on legal paths so illegal words emit a=b=0, ADD.
  always_comb begin
    legal  = 1'b0;
    alu_a  = 32'd0;
    alu_b  = 32'd0;
    alu_op = ALU_ADD;
    case (opcode)
      OPC_OP: begin
        if (f7 == F7_BASE) begin
          legal  = 1'b1;
          alu_op = funct3_op(f3);
        end else if (f7 == F7_ALT && f3 == 3'b000) begin
          legal  = 1'b1;
          alu_op = ALU_SUB;
        end else if (f7 == F7_ALT && f3 == 3'b101) begin
          legal  = 1'b1;
          alu_op = ALU_SRA;
        end
        if (legal) begin
          alu_a = rs1_val;
          alu_b = rs2_val;
        end
      end
      OPC_OP_IMM: begin
        case (f3)
          3'b001: begin
            legal  = (f7 == F7_BASE);
            alu_op = legal ? ALU_SLL : ALU_ADD;
            alu_b  = legal ? shamt : 32'd0;
          end
          3'b101: begin
            legal  = (f7 == F7_BASE) || (f7 == F7_ALT);
            alu_op = !legal ? ALU_ADD : ((f7 == F7_ALT) ? ALU_SRA : ALU_SRL);
            alu_b  = legal ? shamt : 32'd0;
          end
          default: begin
            legal  = 1'b1;
            alu_op = funct3_op(f3);
            alu_b  = imm_i;
          end
        endcase
        alu_a = legal ? rs1_val : 32'd0;
      end
      OPC_LUI: begin
        legal = 1'b1;
        alu_b = imm_u;
      end
      OPC_AUIPC: begin
        legal = 1'b1;
        alu_a = pc;
        alu_b = imm_u;
      end
      default: legal = 1'b0;
    endcase
  end

  assign illegal = !legal;
  assign rd_we   = legal && (instr[11:7] != 5'd0);

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: valid/ready capture into a single registered output slot
// with backpressure hold and flush.
module id_stage
  import risc_pkg::*;
(
  input logic         clk,
  input logic         rst,
  id_stage_if.slave   bus
);

  logic [31:0] dec_a;
  logic [31:0] dec_b;
  alu_op_t     dec_op;
  logic        dec_we;
  logic        dec_ill;

  logic        valid_q,   valid_d;
  logic [31:0] alu_a_q,   alu_a_d;
  logic [31:0] alu_b_q,   alu_b_d;
  alu_op_t     alu_op_q,  alu_op_d;
  logic [4:0]  rd_q,      rd_d;
  logic        rd_we_q,   rd_we_d;
  logic        illegal_q, illegal_d;
  logic [31:0] pc_q,      pc_d;
  logic        in_ready;
  logic        load;

  alu_decoder u_dec (
    .instr    (bus.in_instr),
    .pc       (bus.in_pc),
    .rs1_data (bus.rs1_data),
    .rs2_data (bus.rs2_data),
    .alu_a    (dec_a),
    .alu_b    (dec_b),
    .alu_op   (dec_op),
    .rd_we    (dec_we),
    .illegal  (dec_ill)
  );

  assign in_ready     = !valid_q || bus.out_ready;
  assign load         = bus.in_valid && in_ready && !bus.flush;
  assign bus.in_ready = in_ready;
  assign bus.rs1_addr = bus.in_instr[19:15];
  assign bus.rs2_addr = bus.in_instr[24:20];

  always_comb begin
    valid_d   = valid_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = alu_op_q;
    rd_d      = rd_q;
    rd_we_d   = rd_we_q;
    illegal_d = illegal_q;
    pc_d      = pc_q;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d   = 1'b1;
      alu_a_d   = dec_a;
      alu_b_d   = dec_b;
      alu_op_d  = dec_op;
      rd_d      = bus.in_instr[11:7];
      rd_we_d   = dec_we;
      illegal_d = dec_ill;
      pc_d      = bus.in_pc;
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      alu_a_q   <= 32'd0;
      alu_b_q   <= 32'd0;
      alu_op_q  <= ALU_ADD;
      rd_q      <= 5'd0;
      rd_we_q   <= 1'b0;
      illegal_q <= 1'b0;
      pc_q      <= 32'd0;
    end else begin
      valid_q   <= valid_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_op_q  <= alu_op_d;
      rd_q      <= rd_d;
      rd_we_q   <= rd_we_d;
      illegal_q <= illegal_d;
      pc_q      <= pc_d;
    end
  end

  assign bus.out_valid   = valid_q;
  assign bus.out_alu_a   = alu_a_q;
  assign bus.out_alu_b   = alu_b_q;
  assign bus.out_alu_op  = alu_op_q;
  assign bus.out_rd      = rd_q;
  assign bus.out_rd_we   = rd_we_q;
  assign bus.out_illegal = illegal_q;
  assign bus.out_pc      = pc_q;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed plan steps followed by random traffic, compared
// against an instruction-level reference model of the decode slot.
module tb_id_stage;
  import risc_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_stage_if bus ();
  id_stage dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    alu_op_t     op;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
    logic [31:0] pc;
  } exp_t;

  int errors = 0;
  int checks = 0;
  logic m_valid;
  exp_t m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference decode written straight from the instruction-set rules.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                      input logic [31:0] d1, input logic [31:0] d2);
    alu_op_t map3 [0:7];
    exp_t e;
    int f3, f7;
    logic ok;
    logic [31:0] r1, r2;
    map3 = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    f3 = int'(ins[14:12]);
    f7 = int'(ins[31:25]);
    r1 = (ins[19:15] == 0) ? 32'd0 : d1;
    r2 = (ins[24:20] == 0) ? 32'd0 : d2;
    e = '0;
    e.op = ALU_ADD;
    e.rd = ins[11:7];
    e.pc = pc;
    ok = 1'b0;
    if (ins[6:0] == 7'h33) begin
      ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
      e.op = (f7 == 0) ? map3[f3] : ((f3 == 0) ? ALU_SUB : ALU_SRA);
      e.a = r1; e.b = r2;
    end else if (ins[6:0] == 7'h13) begin
      if (f3 == 1)      ok = (f7 == 0);
      else if (f3 == 5) ok = (f7 == 0) || (f7 == 32);
      else              ok = 1'b1;
      e.op = (f3 == 5 && f7 == 32) ? ALU_SRA : map3[f3];
      e.a = r1;
      e.b = (f3 == 1 || f3 == 5) ? 32'(ins[24:20]) : 32'($signed(ins[31:20]));
    end else if (ins[6:0] == 7'h37) begin
      ok = 1'b1; e.a = 0; e.b = ins & 32'hFFFFF000;
    end else if (ins[6:0] == 7'h17) begin
      ok = 1'b1; e.a = pc; e.b = ins & 32'hFFFFF000;
    end
    if (!ok) begin
      e.a = 0; e.b = 0; e.op = ALU_ADD;
    end
    e.ill = !ok;
    e.we  = ok && (ins[11:7] != 0);
    return e;
  endfunction

  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic [31:0] d1, input logic [31:0] d2,
                      input logic fl, input logic rdy, input logic rs);
    logic exp_ready;
    bus.in_valid = v; bus.in_instr = ins; bus.in_pc = pc;
    bus.rs1_data = d1; bus.rs2_data = d2; bus.flush = fl; bus.out_ready = rdy;
    rst = rs;
    #1;
    exp_ready = !m_valid || rdy;
    if (!rs) chk("in_ready", 32'(bus.in_ready), 32'(exp_ready));
    chk("rs1_addr", 32'(bus.rs1_addr), 32'(ins[19:15]));
    chk("rs2_addr", 32'(bus.rs2_addr), 32'(ins[24:20]));
    @(posedge clk);
    if (rs) begin
      m_valid = 1'b0;
      m = '0;
      m.op = ALU_ADD;
    end else if (fl) begin
      m_valid = 1'b0;
    end else if (v && exp_ready) begin
      m_valid = 1'b1;
      m = ref_decode(ins, pc, d1, d2);
    end else if (rdy) begin
      m_valid = 1'b0;
    end
    #1;
    chk("out_valid",   32'(bus.out_valid),  32'(m_valid));
    chk("out_alu_a",   bus.out_alu_a,       m.a);
    chk("out_alu_b",   bus.out_alu_b,       m.b);
    chk("out_alu_op",  32'(bus.out_alu_op), 32'(m.op));
    chk("out_rd",      32'(bus.out_rd),     32'(m.rd));
    chk("out_rd_we",   32'(bus.out_rd_we),  32'(m.we));
    chk("out_illegal", 32'(bus.out_illegal),32'(m.ill));
    chk("out_pc",      bus.out_pc,          m.pc);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0] f7;
    w = $urandom();
    case ($urandom_range(0, 3))
      0, 1:    f7 = F7_BASE;
      2:       f7 = F7_ALT;
      default: f7 = w[31:25];
    endcase
    if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
    if ($urandom_range(0, 7) == 0) w[19:15] = 5'd0;
    if ($urandom_range(0, 7) == 0) w[24:20] = 5'd0;
    case ($urandom_range(0, 5))
      0, 5:    w = {f7, w[24:7], OPC_OP};
      1:       w = {((w[13:12] == 2'b01) ? f7 : w[31:25]), w[24:7], OPC_OP_IMM};
      2:       w = {w[31:7], OPC_LUI};
      3:       w = {w[31:7], OPC_AUIPC};
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    m_valid = 1'b0;
    m = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    step(0, 32'h0, 32'h0, 0, 0, 0, 1, 1);
    step(0, 32'h0, 32'h0, 0, 0, 0, 1, 1);
    chk("reset_valid_lit", 32'(bus.out_valid), 32'd0);

    step(1, 32'h00500093, 32'h100, 32'hDEAD, 32'hBEEF, 0, 1, 0);
    chk("addi_b_lit",  bus.out_alu_b, 32'd5);
    chk("addi_rd_lit", 32'(bus.out_rd), 32'd1);
    step(1, 32'h402081B3, 32'h104, 32'd10, 32'd3, 0, 1, 0);
    chk("sub_op_lit", 32'(bus.out_alu_op), 32'(ALU_SUB));
    step(1, 32'h40435293, 32'h108, 32'h80000000, 32'h7, 0, 1, 0);
    chk("srai_op_lit", 32'(bus.out_alu_op), 32'(ALU_SRA));
    step(1, 32'h123453B7, 32'h10C, 32'h1, 32'h2, 0, 1, 0);
    chk("lui_b_lit", bus.out_alu_b, 32'h12345000);
    step(1, 32'hFFF00113, 32'h110, 32'h5, 32'h6, 0, 1, 0);

    // Backpressure: second instruction waits three cycles, then lands.
    step(1, 32'h00A00193, 32'h200, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 32'h00B00213, 32'h204, 0, 0, 0, 0, 0);
      chk("bp_ready_lit", 32'(bus.in_ready), 32'd0);
    end
    step(1, 32'h00B00213, 32'h204, 0, 0, 0, 1, 0);
    chk("bp_second_rd_lit", 32'(bus.out_rd), 32'd4);

    step(1, 32'hFFFFFFFF, 32'h300, 32'h11, 32'h22, 0, 1, 0);
    chk("ill_lit", 32'(bus.out_illegal), 32'd1);
    step(1, 32'h402091B3, 32'h304, 32'h11, 32'h22, 0, 1, 0);
    chk("ill_sub_f3_lit", 32'(bus.out_illegal), 32'd1);

    // Flush with a held output and an incoming instruction.
    step(1, 32'h00C00293, 32'h400, 0, 0, 0, 0, 0);
    step(1, 32'h00D00313, 32'h404, 0, 0, 1, 0, 0);
    step(0, 32'h0, 32'h408, 0, 0, 0, 1, 0);
    chk("flush_drop_lit", 32'(bus.out_valid), 32'd0);

    // Reset mid-stream.
    step(1, 32'h00E00393, 32'h500, 0, 0, 0, 0, 0);
    step(1, 32'h00F00413, 32'h504, 0, 0, 0, 0, 1);
    chk("mid_rst_pc_lit", bus.out_pc, 32'd0);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom() & 32'hFFFFFFFC,
           $urandom(), $urandom(), $urandom_range(0, 15) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction decode stage for the RV32I integer pipeline. It accepts one fetched instruction per cycle over a valid/ready handshake and reads source operands from the register file. It decodes the ALU-class instructions (OP, OP-IMM, LUI, AUIPC) into the `alu_op_t` encoding and operand pair consumed by the ALU. Results are held in a single registered output slot, with backpressure and flush toward the execute stage.

## Interface
- No parameters; XLEN fixed at 32.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset; synchronous, active-high
- `in_valid`  in  1  fetch has an instruction
- `in_ready`  out  1  stage can accept this cycle
- `in_instr`  in  32  instruction word
- `in_pc`  in  32  instruction address
- `rs1_addr`, `rs2_addr`  out  5  register file read addresses, combinational from `in_instr[19:15]` / `[24:20]`
- `rs1_data`, `rs2_data`  in  32  register file read data, combinational same cycle
- `flush`  in  1  discard held and incoming instruction
- `out_valid`  out  1  decoded instruction available
- `out_ready`  in  1  execute accepts
- `out_alu_a`, `out_alu_b`  out  32  ALU operands
- `out_alu_op`  out  `alu_op_t`  ALU operation
- `out_rd`  out  5  destination register
- `out_rd_we`  out  1  writeback enable
- `out_illegal`  out  1  instruction not decodable
- `out_pc`  out  32  PC of held instruction

## Operation
- Decode by opcode `in_instr[6:0]`:
  - OP (0110011): a=rs1, b=rs2.
    - funct7=0000000 maps funct3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
    - funct7=0100000 is valid only with funct3 000 (SUB) or 101 (SRA).
  - OP-IMM (0010011): a=rs1, b=sign-extended I-immediate `instr[31:20]`.
    - Non-shift funct3 values use the same funct3 map; SUB does not exist here.
    - Shifts: funct3 001 requires funct7=0000000 (SLL). funct3 101 takes SRL when funct7=0000000 and SRA when funct7=0100000. The operand b is `{27'b0, instr[24:20]}`.
  - LUI (0110111): a=0, b=`{instr[31:12],12'b0}`, ADD.
  - AUIPC (0010111): a=`in_pc`, b=U-immediate, ADD.
- Any other opcode or funct7 combination is illegal: `out_illegal`=1, `out_rd_we`=0, op ADD, a=b=0.
- `out_rd_we` = legal && rd≠0.
- Operand read: rs1/rs2 address 0 forces operand 0 regardless of `rs*_data`.
- Register file write-through is the register file's responsibility.
- Handshake:
  - `in_ready` = !`out_valid` || `out_ready`.
  - A transfer occurs when `in_valid && in_ready`; on a transfer the output slot loads.
  - When `out_valid` is high and `out_ready` is low, every `out_*` holds stable.
- Flush: next cycle `out_valid`=0, regardless of `in_valid` or `out_ready`. An instruction presented during the flush cycle is dropped. Flush has priority over capture.
- Reset: `out_valid`=0, `out_alu_a`/`out_alu_b`/`out_pc`=0, `out_alu_op`=ADD, `out_rd`=0, `out_rd_we`=0, `out_illegal`=0.

## Timing
- Latency 1 cycle: an instruction accepted at edge N is visible on `out_*` after edge N.
- Throughput 1 instruction/cycle while `out_ready`=1.
- `in_ready`, `rs1_addr` and `rs2_addr` are combinational. There is no combinational path from `in_*` to `out_*`.
- Simultaneous acceptance and emission: an output consumed and a new input captured in the same cycle gives back-to-back `out_valid`=1 with new data.
- Reset held mid-stream: the held instruction is lost and the outputs take their reset values.
- First accept possible on the cycle after `rst` deasserts (`in_ready`=1).

## Structure
- `alu_op_t` already lives in `risc_pkg`. Add opcode constants (OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC) and funct7 constants (F7_BASE, F7_ALT) to `risc_pkg`.
- One combinational sub-module, `alu_decoder`, maps instr/pc/rs data to {alu_a, alu_b, alu_op, rd_we, illegal}.
- `id_stage` owns the handshake and output register.

## Test plan
- ADDI x1,x0,5 (0x00500093), `out_ready`=1 → next cycle: `out_alu_a`=0, `out_alu_b`=5, op ADD, `out_rd`=1, `out_rd_we`=1.
- SUB x3,x1,x2 (0x402081B3), `rs1_data`=10, `rs2_data`=3 → op SUB, a=10, b=3, rd=3.
- SRAI x5,x6,4 (0x40435293), `rs1_data`=0x80000000 → op SRA, b=4. Also LUI x7,0x12345 (0x123453B7) → a=0, b=0x12345000, op ADD.
- Backpressure: hold `out_ready`=0 for 3 cycles with a second instruction pending → `in_ready`=0, outputs unchanged for 3 cycles. The second instruction appears one cycle after `out_ready` rises.
- Illegal: 0xFFFFFFFF → `out_illegal`=1, `out_rd_we`=0, op ADD. SUB with funct3=001 (0x402091B3) → also illegal.
- Flush asserted with `in_valid`=1 and a held output → next cycle `out_valid`=0, and the incoming instruction never appears. Assert `rst` mid-stream → all outputs return to their reset values after the edge.
